// File: rtl/pmod_uart.sv
// pmod_uart: 8N1 UART for the PMOD switchbox; define PMOD_UART_FLOWCTRL_EN for RTS/CTS flow control
module pmod_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       uart_rts,
  input  logic       uart_cts
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st_q, rx_st_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic [2:0] tx_bit_q, rx_bit_q, rxd_q;
  logic [7:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic txd_q, tx_ready_q, rx_valid_q, rx_overrun_q, rx_frame_err_q;
  logic cts_ok, rxd_s, rx_fall, tx_tick, rx_tick;
`ifdef PMOD_UART_FLOWCTRL_EN
  logic [1:0] cts_q;
  // two-flop synchronizer for the peer's active-low clear-to-send
  always_ff @(posedge clk or posedge rst)
    if (rst) cts_q <= 2'b11;
    else cts_q <= {cts_q[0], uart_cts};
  assign cts_ok = ~cts_q[1];
  assign uart_rts = rx_valid_q;
`else
  logic unused_cts;
  assign unused_cts = uart_cts;
  assign cts_ok = 1'b1;
  assign uart_rts = 1'b0;
`endif
  // two-flop synchronizer for rxd plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) rxd_q <= 3'b111;
    else rxd_q <= {rxd_q[1:0], uart_rxd};
  assign rxd_s = rxd_q[1];
  assign rx_fall = rxd_q[2] & ~rxd_q[1];
  assign tx_tick = tx_cnt_q == BIT_END;
  assign rx_tick = rx_cnt_q == ((rx_st_q == START) ? HALF_END : BIT_END);
  // transmit FSM: start bit, 8 data bits LSB first from a shift register, stop bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      txd_q <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_cnt_q <= (tx_st_q == IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
      case (tx_st_q)
        IDLE:
          if (tx_valid && tx_ready_q) begin
            tx_sh_q <= tx_data;
            txd_q <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_st_q <= START;
          end else tx_ready_q <= cts_ok;
        START:
          if (tx_tick) begin
            txd_q <= tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
            tx_bit_q <= '0;
            tx_st_q <= DATA;
          end
        DATA:
          if (tx_tick) begin
            txd_q <= (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
            tx_bit_q <= tx_bit_q + 1'b1;
            tx_st_q <= (tx_bit_q == 3'd7) ? STOP : DATA;
          end
        STOP:
          if (tx_tick) begin
            tx_ready_q <= cts_ok;
            tx_st_q <= IDLE;
          end
        default: tx_st_q <= IDLE;
      endcase
    end
  // receive FSM: mid-bit sampling, holding register with overrun and framing error pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_st_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_cnt_q <= (rx_st_q == IDLE || rx_tick) ? '0 : rx_cnt_q + 1'b1;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (rx_st_q)
        IDLE: if (rx_fall) rx_st_q <= START;
        START: if (rx_tick) rx_st_q <= rxd_s ? IDLE : DATA;
        DATA:
          if (rx_tick) begin
            rx_sh_q <= {rxd_s, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_q <= STOP;
          end
        STOP:
          if (rx_tick) begin
            rx_st_q <= IDLE;
            if (!rxd_s) rx_frame_err_q <= 1'b1;
            else if (rx_valid_q && !rx_ready) rx_overrun_q <= 1'b1;
            else begin
              rx_data_q <= rx_sh_q;
              rx_valid_q <= 1'b1;
            end
          end
        default: rx_st_q <= IDLE;
      endcase
    end
  assign tx_ready = tx_ready_q;
  assign uart_txd = txd_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
endmodule
